multiply_unit: RTL and testbench

//  Parametrised, iterative multiply/multiply-accumulate unit for the processor execute stage.

---
 rtl/multiply_unit_pkg.sv | 24 ++
 rtl/multiply_unit_ppu.sv | 21 ++
 rtl/multiply_unit.sv | 154 +++++++++++++++
 tb/tb_multiply_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_unit_pkg.sv
// multiply_unit_pkg: shared types, type-field bit indices and parameter checks for multiply_unit.
// Build option MULTIPLY_UNIT_EARLY_TERM_EN is consumed by multiply_unit.
package multiply_unit_pkg;
    typedef enum logic [2:0] {
        MT_MUL   = 3'b000,
        MT_MLA   = 3'b001,
        MT_UMULL = 3'b100,
        MT_UMLAL = 3'b101,
        MT_SMULL = 3'b110,
        MT_SMLAL = 3'b111
    } mul_type_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_RESP
    } mul_state_t;
    localparam int TYPE_LONG   = 2;
    localparam int TYPE_SIGNED = 1;
    localparam int TYPE_ACC    = 0;
    function automatic bit radix_legal(input int r);
        return (r == 1) || (r == 2) || (r == 4) || (r == 8);
    endfunction
endpackage

// File: rtl/multiply_unit_ppu.sv
// partial_product_unit: WIDTH x RADIX_BITS partial product, shifted into place and added
// to the running 2*WIDTH-bit sum (purely combinational).
module partial_product_unit #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2,
    parameter int SW         = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]      mcand_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    input  logic [SW-1:0]         shift_i,
    input  logic [2*WIDTH-1:0]    sum_i,
    output logic [2*WIDTH-1:0]    sum_o
);
    logic [2*WIDTH-1:0] pp;
    always_comb begin
        pp = '0;
        for (int i = 0; i < RADIX_BITS; i++)
            pp = digit_i[i] ? pp + ({{WIDTH{1'b0}}, mcand_i} << i) : pp;
        sum_o = sum_i + (pp << shift_i);
    end
endmodule

// File: rtl/multiply_unit.sv
// multiply_unit: iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL with valid/ready on both sides.
// Define MULTIPLY_UNIT_EARLY_TERM_EN to end CALC once the remaining multiplier bits are zero.
module multiply_unit
    import multiply_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         type_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [WIDTH-1:0]   c_i,
    input  logic [WIDTH-1:0]   d_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               n_flag_o,
    output logic               z_flag_o
);
    localparam int K  = WIDTH / RADIX_BITS;
    localparam int CW = $clog2(K + 1);
    localparam int SW = $clog2(2 * WIDTH);

    if (!radix_legal(RADIX_BITS) || (WIDTH % RADIX_BITS) != 0) begin : g_param_check
        $error("multiply_unit: RADIX_BITS must be 1, 2, 4 or 8 and divide WIDTH");
    end

    mul_state_t         state_q, state_d;
    logic [2:0]         type_q, type_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               n_q, n_d;
    logic               z_q, z_d;

    logic               accept;
    logic               sgn_in;
    logic               calc_last;
    logic               reserved;
    logic [SW-1:0]      shift;
    logic [2*WIDTH-1:0] pp_sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] total;

    assign req_ready_o  = (state_q == S_IDLE) || (state_q == S_RESP && resp_ready_i);
    assign resp_valid_o = (state_q == S_RESP);
    assign result_o     = result_q;
    assign n_flag_o     = n_q;
    assign z_flag_o     = z_q;

    assign accept   = req_valid_i && req_ready_o;
    assign sgn_in   = type_i[TYPE_LONG] && type_i[TYPE_SIGNED];
    assign reserved = !type_q[TYPE_LONG] && type_q[TYPE_SIGNED];
    assign shift    = SW'(cnt_q * RADIX_BITS);
    // Magnitudes were multiplied unsigned; restore the sign before accumulating.
    assign prod     = neg_q ? -sum_q : sum_q;
    assign total    = prod + acc_q;

`ifdef MULTIPLY_UNIT_EARLY_TERM_EN
    assign calc_last = (cnt_q == CW'(K - 1)) || ((mplier_q >> RADIX_BITS) == '0);
`else
    assign calc_last = (cnt_q == CW'(K - 1));
`endif

    partial_product_unit #(
        .WIDTH(WIDTH),
        .RADIX_BITS(RADIX_BITS),
        .SW(SW)
    ) u_ppu (
        .mcand_i(mcand_q),
        .digit_i(mplier_q[RADIX_BITS-1:0]),
        .shift_i(shift),
        .sum_i(sum_q),
        .sum_o(pp_sum)
    );

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        case (state_q)
            S_CALC: begin
                sum_d    = pp_sum;
                mplier_d = mplier_q >> RADIX_BITS;
                cnt_d    = cnt_q + 1'b1;
                state_d  = calc_last ? S_FIX : S_CALC;
            end
            S_FIX: begin
                result_d = reserved ? '0 :
                           type_q[TYPE_LONG] ? total : {{WIDTH{1'b0}}, total[WIDTH-1:0]};
                n_d      = !reserved && (type_q[TYPE_LONG] ? total[2*WIDTH-1] : total[WIDTH-1]);
                z_d      = reserved || (type_q[TYPE_LONG] ? (total == '0) : (total[WIDTH-1:0] == '0));
                state_d  = S_RESP;
            end
            S_RESP:  state_d = resp_ready_i ? S_IDLE : S_RESP;
            default: state_d = state_q;
        endcase
        if (accept) begin
            state_d  = S_CALC;
            type_d   = type_i;
            mcand_d  = (sgn_in && a_i[WIDTH-1]) ? -a_i : a_i;
            mplier_d = (sgn_in && b_i[WIDTH-1]) ? -b_i : b_i;
            neg_d    = sgn_in && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            acc_d    = !type_i[TYPE_ACC] ? '0 :
                       type_i[TYPE_LONG] ? {c_i, d_i} : {{WIDTH{1'b0}}, c_i};
            sum_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= S_IDLE;
            type_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end
endmodule

// File: tb/tb_multiply_unit.sv
// tb_multiply_unit: scoreboard bench for multiply_unit; expected results and latencies come
// from an arithmetic reference model, a monitor compares them at each response.
module tb_multiply_unit;
    import multiply_unit_pkg::*;
    localparam int W = 32;
    localparam int R = 2;
    localparam int K = W / R;

    typedef struct {
        logic [2*W-1:0] res;
        logic           n;
        logic           z;
        int             lat;
        int             acc_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           n_reset = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [2:0]     type_s = '0;
    logic [W-1:0]   a = '0, b = '0, c = '0, d = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           n_flag, z_flag;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   rr_mode = 1;
    logic prev_v = 1'b0;
    exp_t q[$];

    multiply_unit #(.WIDTH(W), .RADIX_BITS(R)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .type_i(type_s),
        .a_i(a),
        .b_i(b),
        .c_i(c),
        .d_i(d),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .result_o(result),
        .n_flag_o(n_flag),
        .z_flag_o(z_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        resp_ready = (rr_mode == 0) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired waiting for DUT", name);
    endtask

    function automatic exp_t model(input logic [2:0] t, input logic [W-1:0] ma, mb, mc, md);
        exp_t           e;
        logic [2*W-1:0] p;
        logic [W-1:0]   bm;
        int             bl;
        e.acc_cyc = 0;
        if (!t[2] && t[1]) begin
            e.res = '0;
            e.n   = 1'b0;
            e.z   = 1'b1;
        end else if (t[2]) begin
            p = t[1] ? $signed({{W{ma[W-1]}}, ma}) * $signed({{W{mb[W-1]}}, mb})
                     : {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
            if (t[0]) p = p + {mc, md};
            e.res = p;
            e.n   = p[2*W-1];
            e.z   = (p == '0);
        end else begin
            p = {{W{1'b0}}, ma} * {{W{1'b0}}, mb} + (t[0] ? {{W{1'b0}}, mc} : '0);
            e.res = {{W{1'b0}}, p[W-1:0]};
            e.n   = p[W-1];
            e.z   = (p[W-1:0] == '0);
        end
`ifdef MULTIPLY_UNIT_EARLY_TERM_EN
        bm = (t[2] && t[1] && mb[W-1]) ? -mb : mb;
        bl = 0;
        for (int i = 0; i < W; i++) if (bm[i]) bl = i + 1;
        e.lat = ((bl == 0) ? 1 : (bl + R - 1) / R) + 1;
`else
        bm = mb;
        bl = 0;
        e.lat = K + 1;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (!n_reset) prev_v = 1'b0;
        else begin
            if (resp_valid && !prev_v) begin
                if (q.size() == 0) timeout("unexpected_response");
                else check("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
            end
            if (resp_valid && resp_ready && q.size() > 0) begin
                check("result", result, q[0].res);
                check("n_flag", 64'(n_flag), 64'(q[0].n));
                check("z_flag", 64'(z_flag), 64'(q[0].z));
                void'(q.pop_front());
                resp_cnt++;
            end
            prev_v = resp_valid;
        end
    end

    task automatic issue(input logic [2:0] t, input logic [W-1:0] ia, ib, ic, id);
        exp_t e;
        bit   ok = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        type_s = t;
        a = ia;
        b = ib;
        c = ic;
        d = id;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            timeout("req_ready");
            req_valid = 1'b0;
            return;
        end
        e = model(t, ia, ib, ic, id);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = $urandom;
        type_s = 3'($urandom);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = (q.size() == 0) && !resp_valid;
        end
        if (!done) timeout("drain");
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return 1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit   seen;
        int   saved;
        #1 n_reset = 1'b0;
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_result", result, '0);
        check("reset_n_flag", 64'(n_flag), 64'd0);
        check("reset_z_flag", 64'(z_flag), 64'd0);
        @(posedge clk);
        #3 n_reset = 1'b1;
        rr_mode = 1;
        issue(MT_MUL, 7, 6, 0, 0);
        drain();
        issue(MT_SMULL, 32'hFFFF_FFFF, 2, 0, 0);
        drain();
        issue(MT_UMLAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        drain();
        issue(MT_SMLAL, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(MT_MLA, 5, 0, 0, 0);
        drain();
        issue(3'b010, 9, 9, 1, 1);
        drain();
        rr_mode = 2;
        issue(MT_MUL, 3, 3, 0, 0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        if (!seen) timeout("hold_resp_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_result", result, 64'd9);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rr_mode = 1;
        drain();
        issue(MT_MUL, 3, 3, 0, 0);
        repeat (4) @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mid_req_ready", 64'(req_ready), 64'd1);
        check("rst_mid_result", result, '0);
        q.delete();
        saved = resp_cnt;
        @(posedge clk);
        #3 n_reset = 1'b1;
        repeat (40) @(negedge clk);
        check("no_resp_after_reset", 64'(resp_cnt), 64'(saved));
        rr_mode = 0;
        for (int i = 0; i < 300; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick(), pick(), pick());
        rr_mode = 1;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
